pattern_auth: RTL and testbench
===============================

# pattern_auth

Parametrised directional-pattern authenticator with retry lockout and a three-digit seven-segment status display. Four push-button inputs (T, D, L, R) enter a LEN-symbol pattern. The pattern is compared against a stored code under an inter-press timeout. The result drives an unlock strobe, an alarm flag and the board display. This block is the top-level access-control unit of the FPGA design.

## Interface
- LEN, 4: symbols per pattern (2..8).
- CODE, 8'b11_10_10_00: expected pattern, 2 bits per symbol, symbol 0 in LSBs; default is T,L,L,R.
- TIMEOUT, 30: maximum cycles allowed between accepted presses once entry has started.
- MAX_FAIL, 3: consecutive failures that trigger lockout.
- HOLD, 16: cycles spent in GRANT or DENY.
- LOCK_CYCLES, 256: lockout duration.
- REFRESH, 4: cycles per display digit slot.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- T, D, L, R  in  1 each  button levels, already debounced.
- unlock  out  1  high for exactly the HOLD cycles of GRANT.
- alarm  out  1  high throughout LOCK.
- fails  out  $clog2(MAX_FAIL+1)  consecutive-failure count.
- SSG_D  out  7  segments a..g in bits 0..6, active-low.
- SSG_EN  out  3  digit enables, active-low, one-hot-low.

## Operation
- Symbol encoding: T=0, D=1, L=2, R=3.
- A press is a rising edge of a button level, using a one-cycle history register. Exactly one rising edge in a cycle is a valid symbol. Two or more rising edges in the same cycle form one press with an invalid symbol.
- States:
  - IDLE: first press → ENTRY, idx=1. Presses are not timed.
  - ENTRY: each press stores a match/mismatch bit and increments idx. On the LEN-th press, all bits match → GRANT, otherwise → DENY. No early reject on mismatch.
  - ENTRY timeout: no press for TIMEOUT consecutive cycles → DENY.
  - GRANT: lasts HOLD cycles, then → IDLE. fails is cleared on entry.
  - DENY: lasts HOLD cycles. fails increments on entry, saturating at MAX_FAIL. Exit → LOCK if fails==MAX_FAIL, else → IDLE.
  - LOCK: lasts LOCK_CYCLES, then → IDLE. fails is cleared on exit.
- Presses during GRANT, DENY and LOCK are ignored. They do not start a new entry.
- Display by state:
  - IDLE: "---".
  - ENTRY: "E" followed by idx as two decimal digits.
  - GRANT: "OPN".
  - DENY: "ERR".
  - LOCK: "LOC".
- rst low in any state, including mid-entry, forces IDLE on the next edge. This clears idx, fails, the timers and the button history.

## Timing
- Reset values:
  - unlock=0, alarm=0, fails=0.
  - SSG_D=7'h7F (blank), SSG_EN=3'b111.
  - Button history = 0. A button already held when rst releases registers as a press on the first cycle after release.
- Press sampled at edge k: state/idx update is visible after edge k.
- LEN-th press at edge k: unlock=1 from after edge k through HOLD cycles.
- Timeout counter resets to 0 on every accepted press. DENY is entered on the edge where the counter reaches TIMEOUT.
- A press landing on that same edge wins over the timeout.
- Display: one digit active per REFRESH cycles, rotating digit 0→1→2→0. SSG_D changes on the same edge as SSG_EN. Content follows the state with 1 cycle of latency.

## Configuration
- PATTERN_AUTH_PROG_EN defined:
  - Adds input `prog` (1 bit) and a PROG state.
  - `prog` high during GRANT → PROG.
  - The next LEN valid presses overwrite the code register. An invalid press aborts to IDLE with the code unchanged.
  - A TIMEOUT expiry in PROG → IDLE with the code unchanged.
  - Display in PROG is "P" followed by idx.
  - rst reloads the code register from CODE.
- PATTERN_AUTH_PROG_EN undefined: no `prog` port, no PROG state, and the code is the constant CODE.

## Structure
- Package pattern_auth_pkg holds:
  - the state enum;
  - the symbol encoding constants;
  - seven-segment glyph constants (0-9, E, O, P, N, R, L, C, -, blank).
- Sub-module ssg_mux3 handles the refresh counter, digit rotation and the glyph→SSG_D mapping. It takes three glyph codes as input.
- The FSM, timers and comparison stay in pattern_auth.

## Test plan
All scenarios use defaults unless stated.
- Reset, then press T, L, L, R 3 cycles apart → unlock high for 16 cycles starting the cycle after the R edge; display reads "OPN"; fails=0.
- Press D, L, L, R → no unlock; DENY for 16 cycles with "ERR"; fails=1; then back in IDLE.
- Three wrong patterns in a row → after the third DENY, alarm=1 for 256 cycles; a correct pattern entered during LOCK has no effect; fails=0 afterwards, and the next correct pattern unlocks.
- Press T, wait 30 cycles with no press → DENY on the 30th cycle. A second run pressing L at cycle 30 → accepted, and entry continues.
- T and L rising in the same cycle, followed by L, L, R → DENY. Separately, pull rst low after two presses → IDLE with idx=0, and the next T, L, L, R unlocks.
- With PATTERN_AUTH_PROG_EN: unlock, pulse prog, enter R, R, D, T → T, L, L, R now denied and R, R, D, T unlocks; after rst, T, L, L, R unlocks again.

Source files
------------

// File: rtl/pattern_auth_pkg.sv
// Shared types for the pattern authenticator: FSM states, symbol codes and seven-segment glyphs.
// The PROG state exists only when PATTERN_AUTH_PROG_EN is defined.
package pattern_auth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_GRANT,
        ST_DENY,
        ST_LOCK
`ifdef PATTERN_AUTH_PROG_EN
        , ST_PROG
`endif
    } state_t;

    localparam logic [1:0] SYM_T = 2'd0;
    localparam logic [1:0] SYM_D = 2'd1;
    localparam logic [1:0] SYM_L = 2'd2;
    localparam logic [1:0] SYM_R = 2'd3;

    // Glyph codes 0..9 are the decimal digits themselves.
    typedef logic [4:0] glyph_t;
    localparam glyph_t G_E     = 5'd10;
    localparam glyph_t G_O     = 5'd11;
    localparam glyph_t G_P     = 5'd12;
    localparam glyph_t G_N     = 5'd13;
    localparam glyph_t G_R     = 5'd14;
    localparam glyph_t G_L     = 5'd15;
    localparam glyph_t G_C     = 5'd16;
    localparam glyph_t G_DASH  = 5'd17;
    localparam glyph_t G_BLANK = 5'd18;

    // Segments a..g in bits 0..6, returned active-low.
    function automatic logic [6:0] glyph_seg(input glyph_t g);
        logic [6:0] on;
        case (g)
            5'd0:    on = 7'h3F;
            5'd1:    on = 7'h06;
            5'd2:    on = 7'h5B;
            5'd3:    on = 7'h4F;
            5'd4:    on = 7'h66;
            5'd5:    on = 7'h6D;
            5'd6:    on = 7'h7D;
            5'd7:    on = 7'h07;
            5'd8:    on = 7'h7F;
            5'd9:    on = 7'h6F;
            G_E:     on = 7'h79;
            G_O:     on = 7'h3F;
            G_P:     on = 7'h73;
            G_N:     on = 7'h54;
            G_R:     on = 7'h50;
            G_L:     on = 7'h38;
            G_C:     on = 7'h39;
            G_DASH:  on = 7'h40;
            G_BLANK: on = 7'h00;
            default: on = 7'h00;
        endcase
        return ~on;
    endfunction

endpackage

// File: rtl/pattern_auth_ssg_mux3.sv
// Three-digit multiplexed seven-segment driver: each digit is lit for REFRESH cycles in turn,
// with segments and enables registered together so they never skew.
module ssg_mux3
    import pattern_auth_pkg::*;
#(
    parameter int REFRESH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  glyph_t     glyph0,
    input  glyph_t     glyph1,
    input  glyph_t     glyph2,
    output logic [6:0] SSG_D,
    output logic [2:0] SSG_EN
);

    localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;

    logic [RW-1:0] rcnt;
    logic [1:0]    digit;
    glyph_t        cur;

    always_comb begin
        case (digit)
            2'd0:    cur = glyph0;
            2'd1:    cur = glyph1;
            default: cur = glyph2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rcnt   <= '0;
            digit  <= 2'd0;
            SSG_D  <= 7'h7F;
            SSG_EN <= 3'b111;
        end else begin
            SSG_D  <= glyph_seg(cur);
            SSG_EN <= ~(3'b001 << digit);
            if (rcnt == RW'(REFRESH - 1)) begin
                rcnt  <= '0;
                digit <= (digit == 2'd2) ? 2'd0 : digit + 2'd1;
            end else begin
                rcnt <= rcnt + RW'(1);
            end
        end
    end

endmodule

// File: rtl/pattern_auth.sv
// Directional-pattern authenticator with retry lockout and three-digit status display.
// Define PATTERN_AUTH_PROG_EN to add the `prog` input and a code-reprogramming state.
module pattern_auth
    import pattern_auth_pkg::*;
#(
    parameter int              LEN         = 4,
    parameter logic [2*LEN-1:0] CODE       = 8'b11_10_10_00,
    parameter int              TIMEOUT     = 30,
    parameter int              MAX_FAIL    = 3,
    parameter int              HOLD        = 16,
    parameter int              LOCK_CYCLES = 256,
    parameter int              REFRESH     = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            T,
    input  logic                            D,
    input  logic                            L,
    input  logic                            R,
`ifdef PATTERN_AUTH_PROG_EN
    input  logic                            prog,
`endif
    output logic                            unlock,
    output logic                            alarm,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fails,
    output logic [6:0]                      SSG_D,
    output logic [2:0]                      SSG_EN
);

    localparam int CW   = 2 * LEN;
    localparam int IW   = $clog2(LEN + 1);
    localparam int FW   = $clog2(MAX_FAIL + 1);
    localparam int TMAX = (TIMEOUT > HOLD) ? ((TIMEOUT > LOCK_CYCLES) ? TIMEOUT : LOCK_CYCLES)
                                           : ((HOLD > LOCK_CYCLES) ? HOLD : LOCK_CYCLES);
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [IW-1:0] IDX_LEN = IW'(LEN);
    localparam logic [TW-1:0] T_TO    = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] T_HOLD  = TW'(HOLD - 1);
    localparam logic [TW-1:0] T_LOCK  = TW'(LOCK_CYCLES - 1);
    localparam logic [FW-1:0] F_MAX   = FW'(MAX_FAIL);

    state_t          state, state_n;
    logic [IW-1:0]   idx, idx_n;
    logic [TW-1:0]   tmr, tmr_n;
    logic [FW-1:0]   fails_n, fails_inc;
    logic            ok, ok_n;
    logic [3:0]      btn, btn_q, rise;
    logic            press, valid, match;
    logic [1:0]      sym, exp_sym;
    logic [CW-1:0]   code_q;

`ifdef PATTERN_AUTH_PROG_EN
    logic [CW-1:0]   code_n, ncode_q, ncode_n;
`else
    assign code_q = CODE;
`endif

    // Button index equals its symbol code; several simultaneous edges are one invalid press.
    assign btn   = {R, L, D, T};
    assign rise  = btn & ~btn_q;
    assign press = |rise;
    assign valid = press && ((rise & (rise - 4'd1)) == 4'd0);

    always_comb begin
        sym = SYM_T;
        if (rise[1]) sym = SYM_D;
        if (rise[2]) sym = SYM_L;
        if (rise[3]) sym = SYM_R;
    end

    always_comb begin
        exp_sym = code_q[1:0];
        for (int i = 1; i < LEN; i++)
            if (idx == IW'(i)) exp_sym = code_q[2*i +: 2];
    end

    assign match     = valid && (sym == exp_sym);
    assign fails_inc = (fails == F_MAX) ? fails : fails + FW'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            tmr   <= '0;
            fails <= '0;
            ok    <= 1'b0;
            btn_q <= '0;
`ifdef PATTERN_AUTH_PROG_EN
            code_q  <= CODE;
            ncode_q <= '0;
`endif
        end else begin
            state <= state_n;
            idx   <= idx_n;
            tmr   <= tmr_n;
            fails <= fails_n;
            ok    <= ok_n;
            btn_q <= btn;
`ifdef PATTERN_AUTH_PROG_EN
            code_q  <= code_n;
            ncode_q <= ncode_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        tmr_n   = tmr;
        fails_n = fails;
        ok_n    = ok;
`ifdef PATTERN_AUTH_PROG_EN
        code_n  = code_q;
        ncode_n = ncode_q;
`endif
        case (state)
            ST_IDLE: begin
                if (press) begin
                    state_n = ST_ENTRY;
                    idx_n   = IW'(1);
                    ok_n    = match;
                    tmr_n   = '0;
                end
            end
            ST_ENTRY: begin
                // A press on the timeout edge takes priority over the timeout.
                if (press) begin
                    idx_n = idx + IW'(1);
                    ok_n  = ok & match;
                    tmr_n = '0;
                    if (idx_n == IDX_LEN) begin
                        idx_n   = '0;
                        state_n = ok_n ? ST_GRANT : ST_DENY;
                        fails_n = ok_n ? {FW{1'b0}} : fails_inc;
                    end
                end else if (tmr == T_TO) begin
                    state_n = ST_DENY;
                    idx_n   = '0;
                    tmr_n   = '0;
                    fails_n = fails_inc;
                end else begin
                    tmr_n = tmr + TW'(1);
                end
            end
            ST_GRANT: begin
                if (tmr == T_HOLD) begin
                    state_n = ST_IDLE;
                    tmr_n   = '0;
                end else begin
                    tmr_n = tmr + TW'(1);
                end
`ifdef PATTERN_AUTH_PROG_EN
                if (prog) begin
                    state_n = ST_PROG;
                    idx_n   = '0;
                    tmr_n   = '0;
                    ncode_n = '0;
                end
`endif
            end
            ST_DENY: begin
                if (tmr == T_HOLD) begin
                    state_n = (fails == F_MAX) ? ST_LOCK : ST_IDLE;
                    tmr_n   = '0;
                end else begin
                    tmr_n = tmr + TW'(1);
                end
            end
            ST_LOCK: begin
                if (tmr == T_LOCK) begin
                    state_n = ST_IDLE;
                    tmr_n   = '0;
                    fails_n = '0;
                end else begin
                    tmr_n = tmr + TW'(1);
                end
            end
`ifdef PATTERN_AUTH_PROG_EN
            ST_PROG: begin
                // New symbols collect in a staging register; the live code changes only on completion.
                if (press) begin
                    tmr_n = '0;
                    if (!valid) begin
                        state_n = ST_IDLE;
                        idx_n   = '0;
                    end else begin
                        for (int i = 0; i < LEN; i++)
                            if (idx == IW'(i)) ncode_n[2*i +: 2] = sym;
                        idx_n = idx + IW'(1);
                        if (idx_n == IDX_LEN) begin
                            code_n  = ncode_n;
                            state_n = ST_IDLE;
                            idx_n   = '0;
                        end
                    end
                end else if (tmr == T_TO) begin
                    state_n = ST_IDLE;
                    idx_n   = '0;
                    tmr_n   = '0;
                end else begin
                    tmr_n = tmr + TW'(1);
                end
            end
`endif
            default: state_n = ST_IDLE;
        endcase
    end

    assign unlock = (state == ST_GRANT);
    assign alarm  = (state == ST_LOCK);

    glyph_t g0, g1, g2, tens, ones;
    assign tens = glyph_t'(32'(idx) / 32'd10);
    assign ones = glyph_t'(32'(idx) % 32'd10);

    always_comb begin
        g0 = G_DASH;
        g1 = G_DASH;
        g2 = G_DASH;
        case (state)
            ST_ENTRY: begin g0 = G_E; g1 = tens; g2 = ones; end
            ST_GRANT: begin g0 = G_O; g1 = G_P;  g2 = G_N;  end
            ST_DENY:  begin g0 = G_E; g1 = G_R;  g2 = G_R;  end
            ST_LOCK:  begin g0 = G_L; g1 = G_O;  g2 = G_C;  end
`ifdef PATTERN_AUTH_PROG_EN
            ST_PROG:  begin g0 = G_P; g1 = tens; g2 = ones; end
`endif
            default: ;
        endcase
    end

    ssg_mux3 #(.REFRESH(REFRESH)) u_ssg (
        .clk    (clk),
        .rst    (rst),
        .glyph0 (g0),
        .glyph1 (g1),
        .glyph2 (g2),
        .SSG_D  (SSG_D),
        .SSG_EN (SSG_EN)
    );

endmodule

// File: tb/tb_pattern_auth.sv
// Directed bench for pattern_auth: unlock, deny, lockout, timeout, multi-press and reset cases.
module tb_pattern_auth;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       T = 1'b0, D = 1'b0, L = 1'b0, R = 1'b0;
`ifdef PATTERN_AUTH_PROG_EN
    logic       prog = 1'b0;
`endif
    logic       unlock, alarm;
    logic [1:0] fails;
    logic [6:0] SSG_D;
    logic [2:0] SSG_EN;

    int errors = 0;
    int checks = 0;

    // Display words as {digit0, digit1, digit2}, active-low segments.
    localparam logic [20:0] D_OPN  = {7'h40, 7'h0C, 7'h2B};
    localparam logic [20:0] D_ERR  = {7'h06, 7'h2F, 7'h2F};
    localparam logic [20:0] D_DASH = {7'h3F, 7'h3F, 7'h3F};
    localparam logic [20:0] D_E01  = {7'h06, 7'h40, 7'h79};
    localparam logic [20:0] D_E02  = {7'h06, 7'h40, 7'h24};

    pattern_auth dut (
        .clk    (clk),
        .rst    (rst),
        .T      (T),
        .D      (D),
        .L      (L),
        .R      (R),
`ifdef PATTERN_AUTH_PROG_EN
        .prog   (prog),
`endif
        .unlock (unlock),
        .alarm  (alarm),
        .fails  (fails),
        .SSG_D  (SSG_D),
        .SSG_EN (SSG_EN)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int s, input logic v);
        case (s)
            0:       T = v;
            1:       D = v;
            2:       L = v;
            default: R = v;
        endcase
    endtask

    task automatic press(input int s);
        set_btn(s, 1'b1);
        tick();
        set_btn(s, 1'b0);
    endtask

    // Four presses, three cycles apart; returns just after the last press edge.
    task automatic pattern(input int s0, input int s1, input int s2, input int s3);
        press(s0); tick(); tick();
        press(s1); tick(); tick();
        press(s2); tick(); tick();
        press(s3);
    endtask

    task automatic idle_wait();
        repeat (20) tick();
    endtask

    // Counts unlock/alarm over n samples starting now; captures the display over samples 1..12.
    task automatic window(input int n, output int nu, output int na, output logic [20:0] d);
        nu = 0;
        na = 0;
        d  = '1;
        for (int i = 0; i < n; i++) begin
            if (unlock === 1'b1) nu++;
            if (alarm === 1'b1) na++;
            if (i >= 1 && i <= 12) begin
                case (SSG_EN)
                    3'b110:  d[20:14] = SSG_D;
                    3'b101:  d[13:7]  = SSG_D;
                    3'b011:  d[6:0]   = SSG_D;
                    default: ;
                endcase
            end
            tick();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nu, na;
        logic [20:0] d;

        // reset state
        repeat (3) tick();
        chk("rst_unlock", unlock, 1'b0);
        chk("rst_alarm", alarm, 1'b0);
        chk("rst_fails", fails, 2'd0);
        chk("rst_ssg_d", SSG_D, 7'h7F);
        chk("rst_ssg_en", SSG_EN, 3'b111);
        rst = 1'b1;
        tick();

        // correct pattern T,L,L,R
        press(0);
        window(13, nu, na, d);
        chk("entry_disp_e01", d, D_E01);
        press(2); tick(); tick();
        press(2); tick(); tick();
        press(3);
        chk("grant_unlock", unlock, 1'b1);
        window(20, nu, na, d);
        chk("grant_cycles", nu, 16);
        chk("grant_disp", d, D_OPN);
        chk("grant_fails", fails, 2'd0);
        chk("grant_end", unlock, 1'b0);

        // wrong pattern D,L,L,R
        pattern(1, 2, 2, 3);
        chk("deny_unlock", unlock, 1'b0);
        chk("deny_fails1", fails, 2'd1);
        window(20, nu, na, d);
        chk("deny_no_unlock", nu, 0);
        chk("deny_disp", d, D_ERR);
        window(13, nu, na, d);
        chk("idle_disp", d, D_DASH);

        // two more failures -> lockout
        pattern(0, 2, 2, 2);
        chk("deny_fails2", fails, 2'd2);
        idle_wait();
        pattern(3, 3, 3, 3);
        chk("deny_fails3", fails, 2'd3);
        repeat (15) tick();
        chk("lock_not_yet", alarm, 1'b0);
        tick();
        chk("lock_alarm", alarm, 1'b1);
        nu = 0;
        na = 0;
        for (int i = 0; i < 300; i++) begin
            if (alarm === 1'b1) na++;
            if (unlock === 1'b1) nu++;
            T = (i == 10);
            L = (i == 13 || i == 16);
            R = (i == 19);
            tick();
        end
        chk("lock_cycles", na, 256);
        chk("lock_ignores_code", nu, 0);
        chk("lock_fails_clr", fails, 2'd0);
        chk("lock_alarm_off", alarm, 1'b0);
        pattern(0, 2, 2, 3);
        chk("post_lock_unlock", unlock, 1'b1);
        idle_wait();

        // timeout: DENY on the 30th cycle after T
        press(0);
        repeat (29) tick();
        chk("to_before", fails, 2'd0);
        tick();
        chk("to_deny", fails, 2'd1);
        idle_wait();
        // press on the timeout edge wins
        press(0);
        repeat (29) tick();
        press(2);
        chk("to_press_wins", fails, 2'd1);
        tick(); tick();
        press(2); tick(); tick();
        press(3);
        chk("to_cont_unlock", unlock, 1'b1);
        chk("to_cont_fails", fails, 2'd0);
        idle_wait();

        // T and L rising together form one invalid press
        T = 1'b1;
        L = 1'b1;
        tick();
        T = 1'b0;
        L = 1'b0;
        tick(); tick();
        press(2); tick(); tick();
        press(2); tick(); tick();
        press(3);
        chk("multi_unlock", unlock, 1'b0);
        chk("multi_fails", fails, 2'd1);
        idle_wait();

        // reset mid-entry
        press(0); tick(); tick();
        press(2);
        window(13, nu, na, d);
        chk("mid_disp_e02", d, D_E02);
        rst = 1'b0;
        tick();
        chk("mid_rst_en", SSG_EN, 3'b111);
        chk("mid_rst_fails", fails, 2'd0);
        rst = 1'b1;
        window(13, nu, na, d);
        chk("mid_rst_idle", d, D_DASH);
        pattern(0, 2, 2, 3);
        chk("mid_rst_unlock", unlock, 1'b1);
        idle_wait();

        // button held through reset counts as a press after release
        rst = 1'b0;
        T = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        T = 1'b0;
        tick(); tick();
        press(2); tick(); tick();
        press(2); tick(); tick();
        press(3);
        chk("held_press_unlock", unlock, 1'b1);
        idle_wait();

`ifdef PATTERN_AUTH_PROG_EN
        // reprogram to R,R,D,T
        pattern(0, 2, 2, 3);
        chk("prog_grant", unlock, 1'b1);
        prog = 1'b1;
        tick();
        prog = 1'b0;
        chk("prog_enter", unlock, 1'b0);
        tick();
        pattern(3, 3, 1, 0);
        tick(); tick();
        pattern(0, 2, 2, 3);
        chk("prog_old_denied", unlock, 1'b0);
        idle_wait();
        pattern(3, 3, 1, 0);
        chk("prog_new_unlock", unlock, 1'b1);
        idle_wait();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        pattern(0, 2, 2, 3);
        chk("prog_rst_reload", unlock, 1'b1);
        idle_wait();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
